pipe_fetch: RTL

Instruction-fetch stage plus IF/ID pipeline register for the 5-stage pipelined CPU. It holds the PC and drives a variable-latency instruction-memory request/acknowledge interface. It selects the next PC from the decode stage's `pcsource`/`bpc`/`jpc`/register target and presents `inst`/`dpc4` to decode. It obeys the decode-stage load-use stall `wpcir` and inserts NOP bubbles while memory is slow.

---
 rtl/pipe_pkg.sv | 22 ++
 rtl/pipe_fetch_mux4x32.sv | 24 ++
 rtl/pipe_fetch.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for the pipelined CPU fetch stage: next-PC select codes,
// the bubble instruction and the fetch FSM states.
package pipe_pkg;

  localparam logic [1:0] PCS_PC4 = 2'b00;
  localparam logic [1:0] PCS_BR  = 2'b01;
  localparam logic [1:0] PCS_JR  = 2'b10;
  localparam logic [1:0] PCS_J   = 2'b11;

  localparam logic [31:0] NOP_INST = 32'h0000_0000;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_REQ  = 2'b01,
    S_FULL = 2'b10
  } fetch_state_t;

  function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
    pc_plus4 = pc + 32'd4;
  endfunction

endpackage

// File: rtl/pipe_fetch_mux4x32.sv
// 4-to-1 32-bit multiplexer used for next-PC selection.
module mux4x32
  import pipe_pkg::*;
(
  input  logic [31:0] a0,
  input  logic [31:0] a1,
  input  logic [31:0] a2,
  input  logic [31:0] a3,
  input  logic [1:0]  s,
  output logic [31:0] y
);

  // select one of the four inputs
  always_comb begin
    case (s)
      PCS_PC4: y = a0;
      PCS_BR:  y = a1;
      PCS_JR:  y = a2;
      PCS_J:   y = a3;
      default: y = a0;
    endcase
  end

endmodule

// File: rtl/pipe_fetch.sv
// Instruction fetch stage with IF/ID register and variable-latency imem handshake.
// Optional macro PIPE_FLUSH_EN: squash the word after a redirect instead of keeping a delay slot.
module pipe_fetch
  import pipe_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        wpcir,
  input  logic [1:0]  pcsource,
  input  logic [31:0] bpc,
  input  logic [31:0] rpc,
  input  logic [31:0] jpc,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  output logic [31:0] inst,
  output logic [31:0] dpc4,
  output logic        dvalid
);

  fetch_state_t state_r, state_nx_s;
  logic [31:0]  pc_r, pc_nx_s;
  logic         req_r, req_nx_s;
  logic [31:0]  buf_r, buf_nx_s;
  logic         pend_valid_r, pend_valid_nx_s;
  logic [31:0]  pend_target_r, pend_target_nx_s;
  logic [31:0]  inst_r, inst_nx_s;
  logic [31:0]  dpc4_r, dpc4_nx_s;
  logic         dvalid_r, dvalid_nx_s;

  logic [31:0]  pc4_s;
  logic [31:0]  sel_target_s;
  logic         word_avail_s;
  logic [31:0]  word_s;
  logic         xfer_s;
  logic         redirect_s;

  assign pc4_s        = pc_plus4(pc_r);
  assign word_avail_s = ((state_r == S_REQ) && imem_ack) || (state_r == S_FULL);
  assign word_s       = (state_r == S_FULL) ? buf_r : imem_rdata;
  assign xfer_s       = wpcir && word_avail_s;
  assign redirect_s   = dvalid_r && (pcsource != PCS_PC4);

  mux4x32 u_npc_mux (
    .a0 (pc4_s),
    .a1 (bpc),
    .a2 (rpc),
    .a3 (jpc),
    .s  (pcsource),
    .y  (sel_target_s)
  );

  // fetch FSM: request sequencing and holding buffer
  always_comb begin
    state_nx_s = state_r;
    req_nx_s   = req_r;
    buf_nx_s   = buf_r;
    case (state_r)
      S_IDLE: begin
        state_nx_s = S_REQ;
        req_nx_s   = 1'b1;
      end
      S_REQ: begin
        if (imem_ack && !wpcir) begin
          state_nx_s = S_FULL;
          req_nx_s   = 1'b0;
          buf_nx_s   = imem_rdata;
        end else begin
          state_nx_s = S_REQ;
          req_nx_s   = 1'b1;
        end
      end
      S_FULL: begin
        if (wpcir) begin
          state_nx_s = S_REQ;
          req_nx_s   = 1'b1;
        end else begin
          state_nx_s = S_FULL;
          req_nx_s   = 1'b0;
        end
      end
      default: begin
        state_nx_s = S_IDLE;
        req_nx_s   = 1'b0;
      end
    endcase
  end

  // PC, IF/ID and pending-redirect update; everything freezes while decode stalls
  always_comb begin
    pc_nx_s          = pc_r;
    inst_nx_s        = inst_r;
    dpc4_nx_s        = dpc4_r;
    dvalid_nx_s      = dvalid_r;
    pend_valid_nx_s  = pend_valid_r;
    pend_target_nx_s = pend_target_r;
    if (wpcir) begin
      if (xfer_s) begin
        pend_valid_nx_s = 1'b0;
        if (pend_valid_r) begin
          pc_nx_s = pend_target_r;
        end else if (redirect_s) begin
          pc_nx_s = sel_target_s;
        end else begin
          pc_nx_s = pc4_s;
        end
`ifdef PIPE_FLUSH_EN
        if (pend_valid_r || redirect_s) begin
          inst_nx_s   = NOP_INST;
          dvalid_nx_s = 1'b0;
        end else begin
          inst_nx_s   = word_s;
          dpc4_nx_s   = pc4_s;
          dvalid_nx_s = 1'b1;
        end
`else
        inst_nx_s   = word_s;
        dpc4_nx_s   = pc4_s;
        dvalid_nx_s = 1'b1;
`endif
      end else begin
        inst_nx_s   = NOP_INST;
        dvalid_nx_s = 1'b0;
        // the branch leaves decode now, so its target must survive until the next word
        if (redirect_s) begin
          pend_valid_nx_s  = 1'b1;
          pend_target_nx_s = sel_target_s;
        end else begin
          pend_valid_nx_s  = pend_valid_r;
        end
      end
    end else begin
      pc_nx_s = pc_r;
    end
  end

  // state and pipeline registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r       <= S_IDLE;
      pc_r          <= RESET_PC;
      req_r         <= 1'b0;
      buf_r         <= 32'h0000_0000;
      pend_valid_r  <= 1'b0;
      pend_target_r <= 32'h0000_0000;
      inst_r        <= NOP_INST;
      dpc4_r        <= 32'h0000_0000;
      dvalid_r      <= 1'b0;
    end else begin
      state_r       <= state_nx_s;
      pc_r          <= pc_nx_s;
      req_r         <= req_nx_s;
      buf_r         <= buf_nx_s;
      pend_valid_r  <= pend_valid_nx_s;
      pend_target_r <= pend_target_nx_s;
      inst_r        <= inst_nx_s;
      dpc4_r        <= dpc4_nx_s;
      dvalid_r      <= dvalid_nx_s;
    end
  end

  assign imem_req  = req_r;
  assign imem_addr = pc_r;
  assign inst      = inst_r;
  assign dpc4      = dpc4_r;
  assign dvalid    = dvalid_r;

endmodule
